// File: rtl/rate_div_pkg.sv
// Shared speed-level constants and default terminal counts
// for the multi-rate tick divider.
package rate_div_pkg;

  localparam logic [1:0] SPEED_SLOWER  = 2'd0;
  localparam logic [1:0] SPEED_NORMAL  = 2'd1;
  localparam logic [1:0] SPEED_FASTER  = 2'd2;
  localparam logic [1:0] SPEED_EXTREME = 2'd3;

  localparam int unsigned DEF_DIV0 = 3555555;
  localparam int unsigned DEF_DIV1 = 1777777;
  localparam int unsigned DEF_DIV2 = 888888;
  localparam int unsigned DEF_DIV3 = 555555;

  function automatic bit div_fits(
    input longint unsigned div,
    input int unsigned     w
  );
    return (w >= 63) || (div < (64'd1 << w));
  endfunction

endpackage

// File: rtl/rate_div_core.sv
// Phase counter: counts enabled edges up to a terminal value,
// then wraps to zero. Knows nothing about speed levels.
module rate_div_core #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign term_o = (count_q == div_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = term_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/rate_divider_multi.sv
// Four-level tick divider: level mux, boundary-aligned speed
// change with acknowledge, and a wrapping tick counter.
module rate_divider_multi
  import rate_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DIV0        = DEF_DIV0,
  parameter int unsigned DIV1        = DEF_DIV1,
  parameter int unsigned DIV2        = DEF_DIV2,
  parameter int unsigned DIV3        = DEF_DIV3,
  parameter logic [1:0]  DEFAULT_SEL = SPEED_NORMAL,
  parameter int unsigned TICK_W      = 8
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [1:0]        speed_sel,
  output logic              clkout,
  output logic              speed_ack,
  output logic [1:0]        active_speed,
  output logic [TICK_W-1:0] tick_count
);

  if (!(div_fits(DIV0, CNT_W) && div_fits(DIV1, CNT_W) &&
        div_fits(DIV2, CNT_W) && div_fits(DIV3, CNT_W)))
  begin : g_bad_div
    $error("rate_divider_multi: a DIVn does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] D0 = CNT_W'(DIV0);
  localparam logic [CNT_W-1:0] D1 = CNT_W'(DIV1);
  localparam logic [CNT_W-1:0] D2 = CNT_W'(DIV2);
  localparam logic [CNT_W-1:0] D3 = CNT_W'(DIV3);

  logic [1:0]        active_q, active_d;
  logic              clkout_q, clkout_d;
  logic              ack_q, ack_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  logic [CNT_W-1:0] div_sel;
  logic             term;
  logic             pending;
  logic             core_clr;

  always_comb begin
    div_sel = D0;
    unique case (active_q)
      SPEED_SLOWER:  div_sel = D0;
      SPEED_NORMAL:  div_sel = D1;
      SPEED_FASTER:  div_sel = D2;
      SPEED_EXTREME: div_sel = D3;
      default:       div_sel = D0;
    endcase
  end

  assign pending  = (speed_sel != active_q);
  // An idle-edge level change restarts the period from zero.
  assign core_clr = restart | (~en & pending);

  rate_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i  (clkin),
    .rst_i  (reset),
    .clr_i  (core_clr),
    .en_i   (en),
    .div_i  (div_sel),
    .term_o (term)
  );

  always_comb begin
    clkout_d = 1'b0;
    ack_d    = 1'b0;
    active_d = active_q;
    tick_d   = tick_q;
    if (restart) begin
      tick_d = '0;
    end else if (!en) begin
      if (pending) begin
        active_d = speed_sel;
        ack_d    = 1'b1;
      end
    end else if (term) begin
      clkout_d = 1'b1;
      tick_d   = tick_q + 1'b1;
      if (pending) begin
        active_d = speed_sel;
        ack_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      active_q <= DEFAULT_SEL;
      clkout_q <= 1'b0;
      ack_q    <= 1'b0;
      tick_q   <= '0;
    end else begin
      active_q <= active_d;
      clkout_q <= clkout_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
    end
  end

  assign clkout       = clkout_q;
  assign speed_ack    = ack_q;
  assign active_speed = active_q;
  assign tick_count   = tick_q;

endmodule

// File: tb/tb_rate_divider_multi.sv
// Scenario and randomized checks of rate_divider_multi against
// an edge-counting reference model.
module tb_rate_divider_multi;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] speed_sel = 2'd1;
  logic       clkout;
  logic       speed_ack;
  logic [1:0] active_speed;
  logic [7:0] tick_count;

  int tests = 0;
  int fails = 0;

  int         divs [4] = '{9, 4, 2, 0};
  int         m_el;
  logic [1:0] m_lvl;
  logic [7:0] m_tick;
  logic       m_clk;
  logic       m_ack;

  logic [11:0] obs;
  logic [11:0] expv;
  assign obs  = {clkout, speed_ack, active_speed, tick_count};
  assign expv = {m_clk, m_ack, m_lvl, m_tick};

  rate_divider_multi #(
    .CNT_W       (24),
    .DIV0        (9),
    .DIV1        (4),
    .DIV2        (2),
    .DIV3        (0),
    .DEFAULT_SEL (2'd1),
    .TICK_W      (8)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .en           (en),
    .restart      (restart),
    .speed_sel    (speed_sel),
    .clkout       (clkout),
    .speed_ack    (speed_ack),
    .active_speed (active_speed),
    .tick_count   (tick_count)
  );

  always #5 clkin = ~clkin;

  // Model: a period is DIV+1 enabled edges; level switches at its end.
  task automatic step(input bit e, input bit r,
                      input bit [1:0] s, input bit rs);
    en = e;
    restart = r;
    speed_sel = s;
    reset = rs;
    @(posedge clkin);
    if (rs) begin
      m_el = 0; m_lvl = 2'd1; m_tick = 0;
      m_clk = 0; m_ack = 0;
    end else if (r) begin
      m_el = 0; m_tick = 0; m_clk = 0; m_ack = 0;
    end else if (!e) begin
      m_clk = 0;
      m_ack = (s != m_lvl);
      if (s != m_lvl) begin
        m_lvl = s;
        m_el = 0;
      end
    end else begin
      m_el++;
      if (m_el == divs[m_lvl] + 1) begin
        m_el = 0;
        m_clk = 1;
        m_tick = m_tick + 8'd1;
        m_ack = (s != m_lvl);
        m_lvl = s;
      end else begin
        m_clk = 0;
        m_ack = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    repeat (3) step(0, 0, 1, 1);
    tests++;
    if (obs !== 12'h100) begin
      fails++;
      $display("FAIL reset got %h exp %h", obs, 12'h100);
    end
  endtask

  task automatic test_basic;
    for (int e = 1; e <= 15; e++) begin
      step(1, 0, 1, 0);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL basic_model e%0d got %h exp %h", e, obs, expv);
      end
      if (e % 5 == 0) begin
        tests++;
        if (obs !== {1'b1, 1'b0, 2'd1, 8'(e / 5)}) begin
          fails++;
          $display("FAIL basic_tick e%0d got %h", e, obs);
        end
      end else if (clkout !== 1'b0) begin
        fails++;
        $display("FAIL basic_idle e%0d got %b exp 0", e, clkout);
      end
    end
  endtask

  task automatic test_speed_change;
    step(0, 0, 1, 1);
    for (int e = 1; e <= 16; e++) begin
      step(1, 0, (e >= 7) ? 2'd2 : 2'd1, 0);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL chg_model e%0d got %h exp %h", e, obs, expv);
      end
      if (e == 9 && (active_speed !== 2'd1 || speed_ack !== 1'b0)) begin
        fails++;
        $display("FAIL chg_early got %h", obs);
      end
      if (e == 10 && {clkout, speed_ack, active_speed} !== 4'b1110) begin
        fails++;
        $display("FAIL chg_edge10 got %h exp b1110",
                 {clkout, speed_ack, active_speed});
      end
      if ((e == 13 || e == 16) && {clkout, speed_ack} !== 2'b10) begin
        fails++;
        $display("FAIL chg_tick e%0d got %b exp 10", e,
                 {clkout, speed_ack});
      end
    end
  endtask

  task automatic test_en_low;
    step(0, 0, 0, 0);
    tests++;
    if ({clkout, speed_ack, active_speed} !== 4'b0100) begin
      fails++;
      $display("FAIL enlow_ack got %b exp 0100",
               {clkout, speed_ack, active_speed});
    end
    for (int e = 1; e <= 10; e++) begin
      step(1, 0, 0, 0);
      tests++;
      if (clkout !== (e == 10) || obs !== expv) begin
        fails++;
        $display("FAIL enlow_run e%0d got %h exp %h", e, obs, expv);
      end
    end
  endtask

  task automatic test_div0;
    logic [7:0] t0;
    step(0, 0, 3, 0);
    t0 = tick_count;
    for (int i = 1; i <= 256; i++) begin
      step(1, 0, 3, 0);
      tests++;
      if (clkout !== 1'b1 || tick_count !== 8'(t0 + i)) begin
        fails++;
        $display("FAIL div0 i%0d got %b/%h exp 1/%h",
                 i, clkout, tick_count, 8'(t0 + i));
      end
    end
    tests++;
    if (tick_count !== t0 || obs !== expv) begin
      fails++;
      $display("FAIL div0_wrap got %h exp %h", obs, expv);
    end
  endtask

  task automatic test_restart_terminal;
    step(0, 0, 1, 1);
    repeat (4) step(1, 0, 1, 0);
    step(1, 1, 2, 0);
    tests++;
    if (obs !== 12'h100) begin
      fails++;
      $display("FAIL rst_term got %h exp %h", obs, 12'h100);
    end
    for (int e = 1; e <= 5; e++) begin
      step(1, 0, 2, 0);
      tests++;
      if (clkout !== (e == 5) || obs !== expv) begin
        fails++;
        $display("FAIL rst_after e%0d got %h exp %h", e, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 2, 0);
    repeat (2) step(1, 0, 2, 0);
    step(1, 0, 1, 1);
    tests++;
    if (obs !== 12'h100) begin
      fails++;
      $display("FAIL rstmid got %h exp %h", obs, 12'h100);
    end
    for (int e = 1; e <= 5; e++) begin
      step(1, 0, 1, 0);
      tests++;
      if (clkout !== (e == 5)) begin
        fails++;
        $display("FAIL rstmid_tick e%0d got %b exp %b",
                 e, clkout, (e == 5));
      end
    end
  endtask

  task automatic test_toggle;
    step(0, 0, 1, 1);
    for (int e = 1; e <= 5; e++) begin
      step(1, 0, (e <= 2) ? 2'd2 : 2'd1, 0);
    end
    tests++;
    if ({clkout, speed_ack, active_speed} !== 4'b1001) begin
      fails++;
      $display("FAIL toggle got %b exp 1001",
               {clkout, speed_ack, active_speed});
    end
  endtask

  task automatic test_random;
    bit [1:0] s;
    s = 2'd1;
    step(0, 0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 29) == 0, s,
           $urandom_range(0, 199) == 0);
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL random i%0d got %h exp %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    m_el = 0; m_lvl = 2'd1; m_tick = 0; m_clk = 0; m_ack = 0;
    @(negedge clkin);
    test_reset;
    test_basic;
    test_speed_change;
    test_en_low;
    test_div0;
    test_restart_terminal;
    test_reset_mid;
    test_toggle;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
